// File: rtl/nr_div_prenorm.sv
// nr_div_prenorm: normalises |divisor| into [0.5,1.0) as Q2.14 and sign-corrects the dividend.
// Latency: T+2+lz edges from capture (T+1 for a zero divisor); NR_PRENORM_FAST_EN skips 4 zero bits per cycle.
// Backpressure: one operation in flight; result held stable in DONE until out_ready, in_ready low meanwhile.
module nr_div_prenorm #(
    parameter int DW  = 16,
    parameter int WW  = 16,
    parameter int LZW = $clog2(DW)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  d_in,
    input  logic [WW-1:0]  w_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [15:0]    d_norm,
    output logic [WW-1:0]  w_out,
    output logic [LZW-1:0] lz,
    output logic           div_zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DW-1:0]  r_mag;
    logic [LZW-1:0] r_cnt;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [15:0]    r_d_norm;
    logic [WW-1:0]  r_w_out;
    logic           r_div_zero;

    logic           w_accept;
    logic           w_handshake;
    logic [DW-1:0]  w_mag_in;
    logic           w_mag_zero;
    logic [WW-1:0]  w_w_min;
    logic [WW-1:0]  w_w_neg;
    logic [WW-1:0]  w_w_cap;
    logic           w_skip4;

    // r_in_ready is only ever set together with r_state==IDLE, so it doubles as the IDLE qualifier
    assign w_accept    = in_valid && r_in_ready;
    assign w_handshake = r_out_valid && out_ready;

    // Magnitude as DW-bit unsigned: the most negative divisor maps onto 2^(DW-1) without overflow
    assign w_mag_in    = d_in[DW-1] ? (~d_in + 1'b1) : d_in;
    assign w_mag_zero  = (w_mag_in == '0);

    // Negating the most negative dividend would wrap; clamp it to the largest positive value
    assign w_w_min     = {1'b1, {(WW-1){1'b0}}};
    assign w_w_neg     = (w_in == w_w_min) ? ~w_w_min : (~w_in + 1'b1);
    assign w_w_cap     = d_in[DW-1] ? w_w_neg : w_in;

`ifdef NR_PRENORM_FAST_EN
    // Top nibble all zero means four shifts are certainly needed, so take them at once
    assign w_skip4     = (r_mag[DW-1:DW-4] == 4'b0000);
`else
    assign w_skip4     = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign d_norm    = r_d_norm;
    assign w_out     = r_w_out;
    assign lz        = r_cnt;
    assign div_zero  = r_div_zero;

    // Next-state decode for the IDLE -> SHIFT -> DONE sequence
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)        w_state_nxt = w_mag_zero ? DONE : SHIFT;
            SHIFT:   if (r_mag[DW-1])     w_state_nxt = DONE;
            DONE:    if (w_handshake)     w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    // State register; in_ready is registered from the next state so it never depends on inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == IDLE);
        end
    end

    // Operand capture, normalising shifts and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mag       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_d_norm    <= '0;
            r_w_out     <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mag       <= w_mag_in;
                        r_cnt       <= '0;
                        r_w_out     <= w_w_cap;
                        r_d_norm    <= '0;
                        r_div_zero  <= w_mag_zero;
                        r_out_valid <= w_mag_zero;
                    end
                end
                SHIFT: begin
                    if (r_mag[DW-1]) begin
                        // Leading one now sits at bit DW-1: keep the top 14 bits as Q2.14
                        r_d_norm    <= {2'b00, r_mag[DW-1 -: 14]};
                        r_out_valid <= 1'b1;
                    end else if (w_skip4) begin
                        r_mag <= r_mag << 4;
                        r_cnt <= r_cnt + LZW'(4);
                    end else begin
                        r_mag <= r_mag << 1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (w_handshake) r_out_valid <= 1'b0;
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nr_div_prenorm.sv
// tb_nr_div_prenorm: table of operand/result vectors plus stall and mid-operation reset sequences.
// Expected results and latencies come from the table and the shift-count latency formula.
// Results are queued at capture and popped when out_valid is seen.
module tb_nr_div_prenorm;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] d_in;
    logic [15:0] w_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d_norm;
    logic [15:0] w_out;
    logic [3:0]  lz;
    logic        div_zero;

    nr_div_prenorm #(.DW(16), .WW(16), .LZW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_in      (d_in),
        .w_in      (w_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_norm    (d_norm),
        .w_out     (w_out),
        .lz        (lz),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [15:0] w;
        logic [15:0] dn;
        logic [15:0] wo;
        logic [3:0]  lz;
        logic        dz;
    } vec_t;

    typedef struct {
        vec_t v;
        int   t_cap;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   n_err;
    int   n_chk;
    int   cyc;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input vec_t v);
        int lzi;
        lzi = int'(v.lz);
        if (v.dz) return 1;
`ifdef NR_PRENORM_FAST_EN
        return 2 + lzi / 4 + lzi % 4;
`else
        return 2 + lzi;
`endif
    endfunction

    // Present one operand pair, queue its expectation at the capture edge
    task automatic send(input vec_t v);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            n_err++;
            $display("FAIL in_ready_wait: got 0 expected 1 within 40 cycles");
        end
        in_valid = 1'b1;
        d_in     = v.d;
        w_in     = v.w;
        tick();
        e.v     = v;
        e.t_cap = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        d_in     = 16'($urandom);
        w_in     = 16'($urandom);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    endtask

    // Wait for the next result and compare it against the head of the scoreboard
    task automatic collect();
        exp_t e;
        int   n;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            n_chk++;
            n_err++;
            $display("FAIL out_valid_wait: got 0 expected 1 within 60 cycles");
        end else if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_output: got out_valid=1 expected no pending operation");
        end else begin
            e = sb.pop_front();
            chk("latency",  32'(cyc + 1 - e.t_cap), 32'(exp_lat(e.v)));
            chk("d_norm",   {16'd0, d_norm},        {16'd0, e.v.dn});
            chk("w_out",    {16'd0, w_out},         {16'd0, e.v.wo});
            chk("lz",       {28'd0, lz},            {28'd0, e.v.lz});
            chk("div_zero", {31'd0, div_zero},      {31'd0, e.v.dz});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        n_err     = 0;
        n_chk     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        d_in      = 16'h0;
        w_in      = 16'h0;

        tbl[0] = '{16'h4000, 16'h0100, 16'h2000, 16'h0100, 4'd1,  1'b0};
        tbl[1] = '{16'h0001, 16'h0100, 16'h2000, 16'h0100, 4'd15, 1'b0};
        tbl[2] = '{16'hFFFD, 16'h0200, 16'h3000, 16'hFE00, 4'd14, 1'b0};
        tbl[3] = '{16'h0000, 16'h0005, 16'h0000, 16'h0005, 4'd0,  1'b1};
        tbl[4] = '{16'h8000, 16'h8000, 16'h2000, 16'h7FFF, 4'd0,  1'b0};
        tbl[5] = '{16'h7FFF, 16'h1234, 16'h3FFF, 16'h1234, 4'd1,  1'b0};
        tbl[6] = '{16'h0123, 16'h8000, 16'h2460, 16'h8000, 4'd7,  1'b0};
        tbl[7] = '{16'hF000, 16'h0007, 16'h2000, 16'hFFF9, 4'd3,  1'b0};
        tbl[8] = '{16'hFFFF, 16'h0001, 16'h2000, 16'hFFFF, 4'd15, 1'b0};
        tbl[9] = '{16'h0000, 16'h8000, 16'h0000, 16'h8000, 4'd0,  1'b1};

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_d_norm",    {16'd0, d_norm},    32'd0);
        chk("rst_w_out",     {16'd0, w_out},     32'd0);
        chk("rst_lz",        {28'd0, lz},        32'd0);
        chk("rst_div_zero",  {31'd0, div_zero},  32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready",  {31'd0, in_ready},  32'd1);

        // Table vectors with out_ready held high
        for (int i = 0; i < 10; i++) begin
            send(tbl[i]);
            collect();
            tick();
            chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
            chk("post_hs_in_ready",  {31'd0, in_ready},  32'd1);
        end

        // Stall in DONE for 5 cycles while a second operand is offered
        out_ready = 1'b0;
        send(tbl[0]);
        collect();
        in_valid = 1'b1;
        d_in     = 16'h0002;
        w_in     = 16'h0003;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_in_ready",  {31'd0, in_ready},  32'd0);
            chk("stall_d_norm",    {16'd0, d_norm},    32'h2000);
            chk("stall_w_out",     {16'd0, w_out},     32'h0100);
            chk("stall_lz",        {28'd0, lz},        32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("stall_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("stall_hs_in_ready",  {31'd0, in_ready},  32'd1);
        // The held operand is taken only now, at the next edge
        v = '{16'h0002, 16'h0003, 16'h2000, 16'h0003, 4'd14, 1'b0};
        tick();
        sb.push_back('{v, cyc});
        in_valid = 1'b0;
        collect();
        tick();

        // Reset pulled low five edges into an operation
        send(tbl[1]);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        sb.delete();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("mid_rst_d_norm",    {16'd0, d_norm},    32'd0);
        chk("mid_rst_w_out",     {16'd0, w_out},     32'd0);
        chk("mid_rst_lz",        {28'd0, lz},        32'd0);
        chk("mid_rst_div_zero",  {31'd0, div_zero},  32'd0);
        rst_n = 1'b1;
        tick();
        chk("mid_rel_in_ready",  {31'd0, in_ready},  32'd1);
        chk("mid_rel_out_valid", {31'd0, out_valid}, 32'd0);

        // Normal operation resumes after the reset
        send(tbl[2]);
        collect();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
